// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: producer-side register scoreboard beside the ID/EX register.
// Counts outstanding writes per architectural register, clears them at writeback
// or when a squashed writer is killed, and generates the decode-stage stall.
// Optional feature macro: SCOREBOARD_FWD_EN. When it is defined, ALU results are
// assumed forwarded and only the one-cycle load-use bubble stalls. When it is
// undefined, a busy source stalls until its last outstanding write retires.
module hazard_scoreboard #(
    parameter int MAX_INFLIGHT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs1,
    input  logic [4:0]  issue_rs2,
    input  logic        issue_rs1_used,
    input  logic        issue_rs2_used,
    input  logic [4:0]  issue_rd,
    input  logic        issue_regwrite,
    input  logic        issue_is_load,
    output logic        issue_ready,
    output logic        stall,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        kill_valid,
    input  logic [4:0]  kill_rd,
    output logic [31:0] busy_vec
);

    localparam int CW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_INFLIGHT);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    // Per-register state; entry 0 is never written and stays at its reset value.
    logic [CW-1:0] cnt_q [32];
    logic [CW-1:0] cnt_d [32];
    logic          ld_q  [32];
    logic          ld_d  [32];
    logic [1:0]    age_q [32];
    logic [1:0]    age_d [32];

    logic rs1_busy, rs2_busy;
    logic rs1_haz, rs2_haz;
    logic waw_block;
    logic accept;

    // Source hazards, WAW limit and the resulting issue handshake.
    always_comb begin
        // NOTE: every variable assigned in this block gets a value on every path
        // (defaults first), otherwise synthesis infers a latch.
        rs1_busy  = 1'b0;
        rs2_busy  = 1'b0;
        waw_block = 1'b0;

        // A sole outstanding write retiring this cycle is visible through the
        // register file (write-before-read), so it does not count as busy.
        if (issue_rs1_used && issue_rs1 != 5'd0 && cnt_q[issue_rs1] != '0)
            rs1_busy = !(wb_valid && wb_rd == issue_rs1 && cnt_q[issue_rs1] == CNT_ONE);
        if (issue_rs2_used && issue_rs2 != 5'd0 && cnt_q[issue_rs2] != '0)
            rs2_busy = !(wb_valid && wb_rd == issue_rs2 && cnt_q[issue_rs2] == CNT_ONE);

`ifdef SCOREBOARD_FWD_EN
        // Only a load that issued last cycle has no value to forward yet.
        rs1_haz = rs1_busy && ld_q[issue_rs1] && age_q[issue_rs1] == 2'd0;
        rs2_haz = rs2_busy && ld_q[issue_rs2] && age_q[issue_rs2] == 2'd0;
`else
        rs1_haz = rs1_busy;
        rs2_haz = rs2_busy;
`endif

        // A full counter blocks a new writer unless a retire frees a slot now.
        if (issue_regwrite && issue_rd != 5'd0 && cnt_q[issue_rd] == CNT_MAX)
            waw_block = !((wb_valid && wb_rd == issue_rd) ||
                          (kill_valid && kill_rd == issue_rd));

        issue_ready = !issue_valid || !(rs1_haz || rs2_haz || waw_block);
        stall       = issue_valid && !issue_ready;
        accept      = issue_valid && issue_ready && issue_regwrite && issue_rd != 5'd0;
    end

    // Next-state per register: net of accept/wb/kill, floored at zero.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
            cnt_d[r] = cnt_q[r];
            ld_d[r]  = ld_q[r];
            age_d[r] = age_q[r];
        end
        for (int r = 1; r < 32; r++) begin
            logic acc_hit, wb_hit, kill_hit;
            int   n;
            acc_hit  = accept && issue_rd == 5'(r);
            wb_hit   = wb_valid && wb_rd == 5'(r);
            kill_hit = kill_valid && kill_rd == 5'(r);
            n = int'(cnt_q[r]) + int'(acc_hit) - int'(wb_hit) - int'(kill_hit);
            if (n < 0)
                n = 0;
            cnt_d[r] = CW'(n);
            if (acc_hit) begin
                ld_d[r]  = issue_is_load;
                age_d[r] = 2'd0;
            end else if (age_q[r] != 2'd3) begin
                age_d[r] = age_q[r] + 2'd1;
            end
        end
    end

    // State registers; the whole table clears asynchronously on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this table is built from flops, not RAM, so it can and must be
            // reset: a stale count after reset would stall decode forever.
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= '0;
                ld_q[r]  <= 1'b0;
                age_q[r] <= 2'd0;
            end
        end else begin
            // NOTE: non-blocking assignments so every entry updates from the
            // pre-edge state, independent of statement order.
            for (int r = 0; r < 32; r++) begin
                cnt_q[r] <= cnt_d[r];
                ld_q[r]  <= ld_d[r];
                age_q[r] <= age_d[r];
            end
        end
    end

    // Busy view of the table; x0 is never busy.
    always_comb begin
        busy_vec = '0;
        for (int r = 1; r < 32; r++)
            busy_vec[r] = (cnt_q[r] != '0);
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed stimulus with a scoreboard queue. The driver sets
// inputs just after each rising edge and pushes the hand-computed expected
// issue_ready/stall/busy_vec; a monitor pops and compares on the falling edge.
module tb_hazard_scoreboard;

`ifdef SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        issue_valid, issue_rs1_used, issue_rs2_used;
    logic [4:0]  issue_rs1, issue_rs2, issue_rd, wb_rd, kill_rd;
    logic        issue_regwrite, issue_is_load, wb_valid, kill_valid;
    logic        issue_ready, stall;
    logic [31:0] busy_vec;

    typedef struct {
        string       name;
        logic        ready;
        logic        stall;
        logic [31:0] busy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    hazard_scoreboard #(.MAX_INFLIGHT(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .issue_valid    (issue_valid),
        .issue_rs1      (issue_rs1),
        .issue_rs2      (issue_rs2),
        .issue_rs1_used (issue_rs1_used),
        .issue_rs2_used (issue_rs2_used),
        .issue_rd       (issue_rd),
        .issue_regwrite (issue_regwrite),
        .issue_is_load  (issue_is_load),
        .issue_ready    (issue_ready),
        .stall          (stall),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .kill_valid     (kill_valid),
        .kill_rd        (kill_rd),
        .busy_vec       (busy_vec)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: compares the DUT outputs against the oldest queued expectation.
    always @(negedge clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            check({e.name, ".ready"}, 32'(issue_ready), 32'(e.ready));
            check({e.name, ".stall"}, 32'(stall), 32'(e.stall));
            check({e.name, ".busy"}, busy_vec, e.busy);
        end
    end

    function automatic logic [31:0] b(input int r);
        return 32'd1 << r;
    endfunction

    task automatic clr();
        issue_valid = 0; issue_rs1 = 0; issue_rs2 = 0; issue_rs1_used = 0;
        issue_rs2_used = 0; issue_rd = 0; issue_regwrite = 0; issue_is_load = 0;
        wb_valid = 0; wb_rd = 0; kill_valid = 0; kill_rd = 0;
    endtask

    task automatic next();
        @(posedge clk);
        #1;
        clr();
    endtask

    task automatic wr(input logic [4:0] rd, input logic ld);
        issue_valid = 1; issue_regwrite = 1; issue_rd = rd; issue_is_load = ld;
    endtask

    task automatic src1(input logic [4:0] s);
        issue_valid = 1; issue_rs1 = s; issue_rs1_used = 1;
    endtask

    task automatic wb(input logic [4:0] r);
        wb_valid = 1; wb_rd = r;
    endtask

    task automatic kill(input logic [4:0] r);
        kill_valid = 1; kill_rd = r;
    endtask

    task automatic push(input string name, input logic rdy, input logic [31:0] busy);
        exp_t e;
        e.name  = name;
        e.ready = rdy;
        e.stall = issue_valid && !rdy;
        e.busy  = busy;
        q.push_back(e);
    endtask

    initial begin
        clr();
        // Reset held two cycles with a valid writer presented.
        next(); wr(5, 0); src1(5); push("rst0", 1, 0);
        next(); wr(5, 0); src1(5); push("rst1", 1, 0);
        next(); rst_n = 1;

        // ALU RAW on x5.
        wr(5, 0); src1(1); push("add_x5", 1, 0);
        next(); src1(5); push("raw_t1", FWD, b(5));
        next(); src1(5); push("raw_t2", FWD, b(5));
        next(); src1(5); wb(5); push("raw_wb_bypass", 1, b(5));
        next(); push("raw_idle", 1, 0);

        // Load-use on x7 and an unused rs2 naming a fresh load.
        next(); wr(7, 1); push("lw_x7", 1, 0);
        next(); issue_valid = 1; issue_rs2 = 7; issue_rs2_used = 1; push("lu_t1", 0, b(7));
        next(); issue_valid = 1; issue_rs2 = 7; issue_rs2_used = 1; push("lu_t2", FWD, b(7));
        next(); wr(8, 1); push("lw_x8", 1, b(7));
        next(); src1(0); issue_rs2 = 8; push("rs2_unused", 1, b(7) | b(8));
        next(); wb(7); push("wb_x7", 1, b(7) | b(8));
        next(); wb(8); push("wb_x8", 1, b(8));

        // WAW saturation on x9.
        next(); wr(9, 0); push("waw1", 1, 0);
        next(); wr(9, 0); push("waw2", 1, b(9));
        next(); wr(9, 0); push("waw3", 1, b(9));
        next(); wr(9, 0); push("waw4_block", 0, b(9));
        next(); wr(9, 0); wb(9); push("waw4_wb_lift", 1, b(9));
        next(); wr(9, 0); push("waw_still_full", 0, b(9));
        next(); wb(9); push("waw_ret1", 1, b(9));
        next(); wb(9); push("waw_ret2", 1, b(9));
        next(); wb(9); push("waw_ret3", 1, b(9));

        // x0 is never tracked.
        next(); wr(0, 0); src1(0); wb(0); kill(0); push("x0_ops", 1, 0);
        next(); push("x0_after", 1, 0);

        // Kill and underflow on x3.
        next(); wr(3, 0); push("iss_x3", 1, 0);
        next(); kill(3); push("kill_x3", 1, b(3));
        next(); kill(3); push("kill_x3_again", 1, 0);
        next(); push("kill_after", 1, 0);

        // Simultaneous accept/wb/kill on x12 from cnt 1 and cnt 2.
        next(); wr(12, 0); push("x12_a", 1, 0);
        next(); wr(12, 0); wb(12); kill(12); push("x12_triple_c1", 1, b(12));
        next(); push("x12_c1_end", 1, 0);
        next(); wr(12, 0); push("x12_b1", 1, 0);
        next(); wr(12, 0); push("x12_b2", 1, b(12));
        next(); wr(12, 1); wb(12); kill(12); push("x12_triple_c2", 1, b(12));
        next(); src1(12); push("x12_use_t1", 0, b(12));
        next(); src1(12); push("x12_use_t2", FWD, b(12));
        next(); src1(12); wb(12); push("x12_use_wb", 1, b(12));
        next(); push("x12_end", 1, 0);

        // Reset in mid-operation.
        next(); wr(4, 0); push("mid_x4", 1, 0);
        next(); wr(10, 0); push("mid_x10", 1, b(4));
        next(); rst_n = 0; src1(4); push("mid_rst", 1, 0);
        next(); rst_n = 1; src1(4); push("post_rst", 1, 0);
        next();

        for (int i = 0; i < 5 && q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

- Producer-side companion to the forwarding unit.
- Records every register write accepted at issue (ID→EX) and clears it when that write retires at writeback.
- Drives the decode-stage stall so the forwarding network is only asked for values that already exist.
- Sits beside the ID/EX pipeline register; issue-side inputs come from decode, retire-side inputs from MEM/WB and the flush logic.

## Interface
- MAX_INFLIGHT, 3: maximum outstanding writes per register; count width is clog2(MAX_INFLIGHT+1).
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode presents an instruction.
- issue_rs1, issue_rs2  in  5  source indices.
- issue_rs1_used, issue_rs2_used  in  1  source actually read.
- issue_rd  in  5  destination index.
- issue_regwrite  in  1  instruction writes issue_rd.
- issue_is_load  in  1  instruction is a load.
- issue_ready  out  1  instruction may advance into EX this cycle.
- stall  out  1  equals issue_valid && !issue_ready.
- wb_valid  in  1  writeback of wb_rd this cycle.
- wb_rd  in  5  retiring destination.
- kill_valid  in  1  a squashed, already-issued writer will never write back.
- kill_rd  in  5  its destination.
- busy_vec  out  32  bit r = register r has at least one outstanding write; bit 0 always 0.

## Operation
Per register r in 1..31, the block keeps:
- cnt[r]: outstanding writers.
- ld[r]: youngest writer is a load.
- age[r]: 2-bit count of cycles since the youngest writer issued; saturates at 3.

Hazard check, per used source s ≠ 0:
- s is hazardous if cnt[s] ≠ 0, unless wb_valid && wb_rd == s && cnt[s] == 1. Same-cycle writeback bypass: the register file writes before it reads.
- With forwarding compiled in, see Configuration.

WAW limit:
- issue_regwrite && issue_rd ≠ 0 && cnt[issue_rd] == MAX_INFLIGHT also blocks issue_ready.
- A same-cycle wb or kill on that register lifts the block.

issue_ready:
- 1 when no hazard and no WAW limit.
- 1 whenever issue_valid == 0.

Accept = issue_valid && issue_ready && issue_regwrite && issue_rd ≠ 0. For rd = issue_rd:
- cnt increments.
- ld ← issue_is_load.
- age ← 0.

Retire:
- wb_valid with wb_rd ≠ 0 decrements cnt[wb_rd].
- kill_valid with kill_rd ≠ 0 decrements cnt[kill_rd].
- Decrement of a zero count is ignored; no underflow.

Simultaneous events on one register are applied as the net sum of +1 (accept), −1 (wb) and −1 (kill), floored at 0. Accept still updates ld and age.

Age:
- Increments every cycle in which no accept targets the register.
- ld and age are don't-care when cnt == 0.

Register 0:
- Never tracked.
- Never stalls.
- Accept, wb and kill on x0 are ignored.

## Timing
- Reset: all cnt/ld/age = 0; busy_vec = 0; issue_ready = 1; stall = 0.
- issue_ready, stall: combinational from current state and same-cycle wb inputs; no registered latency.
- State visible the cycle after the edge that updated it.
- Reset asserted mid-operation clears all entries immediately. The first cycle after deassertion behaves as post-reset.
- Stall does not consume the instruction; decode holds inputs stable until issue_ready.

## Configuration
SCOREBOARD_FWD_EN:
- Defined: a busy source is hazardous only if ld[s] && age[s] == 0, i.e. the one-cycle load-use bubble; ALU results are assumed forwarded. The WAW limit and the same-cycle wb bypass still apply.
- Undefined: any busy source stalls until its last outstanding write retires. This is the no-forwarding pipeline.

## Test plan
- Reset:
  - rst_n low for 2 cycles with issue_valid = 1 → issue_ready = 1 and busy_vec = 0 throughout and after release.
- ALU RAW:
  - Issue add x5 at cycle t, then an x5 consumer at t+1.
  - FWD_EN: no stall.
  - Without FWD_EN: stall asserts until wb_valid/wb_rd = 5; that cycle issue_ready = 1 via bypass.
- Load-use, FWD_EN:
  - lw x7 issues at t, then an x7 consumer at t+1 → stall for exactly 1 cycle; accepted at t+2.
  - A consumer with issue_rs2_used = 0 and rs2 = 7 → no stall.
- WAW saturation:
  - Three writes to x9 without retirement → cnt = 3; a fourth writer stalls.
  - wb of x9 in the same cycle → accepted, cnt stays 3.
- Kill and underflow:
  - Issue x3, then kill_rd = 3 → busy_vec[3] = 0.
  - Further kill_rd = 3 → cnt stays 0, no error.
- Simultaneous accept, wb, kill on x12:
  - Starting cnt = 1 → cnt ends 0, busy_vec[12] = 0.
  - Starting cnt = 2 → cnt ends 1, ld/age reflect the new writer.
